// File: rtl/blackjack_table.sv
// Two-hand blackjack round sequencer. It requests cards from the deck controller over a
// four-phase handshake, keeps soft-ace totals for both hands, and reports the round outcome.
module blackjack_table #(
    parameter logic [4:0] DEALER_STAND = 5'd17,
    parameter logic [7:0] TIMEOUT      = 8'd255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       game_ready,
    input  logic       card_ready,
    input  logic [7:0] card_in,
    input  logic       new_round,
    input  logic       hit,
    input  logic       stand,
    output logic       get_card,
    output logic [4:0] player_score,
    output logic [4:0] dealer_score,
    output logic [3:0] player_cards,
    output logic [3:0] dealer_cards,
    output logic       player_turn,
    output logic [1:0] result,
    output logic       blackjack,
    output logic       fault
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_WAIT_GAME = 4'd1, S_REQ = 4'd2, S_ACK = 4'd3, S_REL = 4'd4, S_ADD = 4'd5,
        S_PLAYER_TURN = 4'd6, S_DEALER_TURN = 4'd7, S_COMPARE = 4'd8, S_DONE = 4'd9, S_FAULT = 4'd10
    } state_t;

    function automatic logic [4:0] card_value(input logic [3:0] rank);
        case (rank)
            4'd1:               card_value = 5'd11;
            4'd11, 4'd12, 4'd13: card_value = 5'd10;
            4'd0, 4'd14, 4'd15: card_value = 5'd0;
            default:            card_value = {1'b0, rank};
        endcase
    endfunction

    function automatic logic card_valid(input logic [3:0] rank);
        card_valid = (rank != 4'd0) && (rank <= 4'd13);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] count);
        sat_inc = (count == 4'd15) ? 4'd15 : count + 4'd1;
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  card_r;
    logic [2:0]  deal_idx_r;
    logic        target_r;
    logic [7:0]  timeout_r;
    logic [3:0]  player_soft_r, dealer_soft_r;
    logic        get_card_r, player_turn_r, blackjack_r, fault_r;
    logic [4:0]  player_score_r, dealer_score_r;
    logic [3:0]  player_cards_r, dealer_cards_r;
    logic [1:0]  result_r;
    logic        target_s;
    logic [4:0]  base_score_s, sum_s, new_score_s;
    logic [3:0]  base_soft_s, soft_sum_s, new_soft_s;
    logic [1:0]  compare_s;
    logic        unused_bits_s;

    assign unused_bits_s = ^card_in[7:4];

    // Hand targeted by the card in flight: fixed P,D,P,D during the deal, then set by whose turn it is.
    assign target_s     = (deal_idx_r < 3'd4) ? deal_idx_r[0] : target_r;
    assign base_score_s = target_s ? dealer_score_r : player_score_r;
    assign base_soft_s  = target_s ? dealer_soft_r : player_soft_r;
    // A hand only draws while at most 20, so the raw sum peaks at 31 and fits five bits.
    assign sum_s        = base_score_s + card_value(card_r);
    assign soft_sum_s   = base_soft_s + ((card_r == 4'd1) ? 4'd1 : 4'd0);

    // Soft-ace demotion applied in the same cycle as the add.
    always_comb begin
        new_score_s = sum_s;
        new_soft_s  = soft_sum_s;
        if ((sum_s > 5'd21) && (soft_sum_s != 4'd0)) begin
            new_score_s = sum_s - 5'd10;
            new_soft_s  = soft_sum_s - 4'd1;
        end else begin
            new_score_s = sum_s;
            new_soft_s  = soft_sum_s;
        end
    end

    // Round outcome from the final totals.
    always_comb begin
        compare_s = 2'b11;
        if (player_score_r > 5'd21) begin
            compare_s = 2'b10;
        end else if (dealer_score_r > 5'd21) begin
            compare_s = 2'b01;
        end else if (player_score_r > dealer_score_r) begin
            compare_s = 2'b01;
        end else if (player_score_r < dealer_score_r) begin
            compare_s = 2'b10;
        end else begin
            compare_s = 2'b11;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE, S_DONE, S_FAULT: begin
                if (new_round) state_s = S_WAIT_GAME;
                else           state_s = state_r;
            end
            S_WAIT_GAME: begin
                if (game_ready) state_s = S_REQ;
                else            state_s = S_WAIT_GAME;
            end
            S_REQ: begin
                if (!game_ready)              state_s = S_FAULT;
                else if (card_ready)          state_s = S_ACK;
                else if (timeout_r == TIMEOUT) state_s = S_FAULT;
                else                          state_s = S_REQ;
            end
            S_ACK: begin
                if (!game_ready) state_s = S_FAULT;
                else             state_s = S_REL;
            end
            S_REL: begin
                if (!game_ready)     state_s = S_FAULT;
                else if (!card_ready) state_s = S_ADD;
                else                 state_s = S_REL;
            end
            S_ADD: begin
                if (!card_valid(card_r))          state_s = S_FAULT;
                else if (deal_idx_r < 3'd3)       state_s = S_REQ;
                else if (deal_idx_r == 3'd3)      state_s = (player_score_r == 5'd21) ? S_DEALER_TURN : S_PLAYER_TURN;
                else if (target_s)                state_s = S_DEALER_TURN;
                else if (new_score_s > 5'd21)     state_s = S_COMPARE;
                else if (new_score_s == 5'd21)    state_s = S_DEALER_TURN;
                else                              state_s = S_PLAYER_TURN;
            end
            S_PLAYER_TURN: begin
                if (stand)    state_s = S_DEALER_TURN;
                else if (hit) state_s = S_REQ;
                else          state_s = S_PLAYER_TURN;
            end
            S_DEALER_TURN: begin
                if (dealer_score_r < DEALER_STAND) state_s = S_REQ;
                else                               state_s = S_COMPARE;
            end
            S_COMPARE: state_s = S_DONE;
            default:   state_s = S_IDLE;
        endcase
    end

    // Registered outputs and hand datapath.
    always_ff @(posedge clock) begin
        if (reset) begin
            get_card_r     <= 1'b0;
            player_turn_r  <= 1'b0;
            fault_r        <= 1'b0;
            blackjack_r    <= 1'b0;
            result_r       <= 2'b00;
            player_score_r <= 5'd0;
            dealer_score_r <= 5'd0;
            player_cards_r <= 4'd0;
            dealer_cards_r <= 4'd0;
            player_soft_r  <= 4'd0;
            dealer_soft_r  <= 4'd0;
            timeout_r      <= 8'd0;
            deal_idx_r     <= 3'd0;
            target_r       <= 1'b0;
            card_r         <= 4'd0;
        end else begin
            get_card_r    <= (state_s == S_REQ);
            player_turn_r <= (state_s == S_PLAYER_TURN);
            fault_r       <= (state_s == S_FAULT);
            timeout_r     <= (state_r == S_REQ) ? timeout_r + 8'd1 : 8'd0;
            case (state_r)
                S_IDLE, S_DONE, S_FAULT: begin
                    if (new_round) begin
                        blackjack_r    <= 1'b0;
                        result_r       <= 2'b00;
                        player_score_r <= 5'd0;
                        dealer_score_r <= 5'd0;
                        player_cards_r <= 4'd0;
                        dealer_cards_r <= 4'd0;
                        player_soft_r  <= 4'd0;
                        dealer_soft_r  <= 4'd0;
                        deal_idx_r     <= 3'd0;
                    end
                end
                S_REQ: begin
                    if (card_ready) card_r <= card_in[3:0];
                end
                S_ADD: begin
                    if (card_valid(card_r)) begin
                        if (target_s) begin
                            dealer_score_r <= new_score_s;
                            dealer_soft_r  <= new_soft_s;
                            dealer_cards_r <= sat_inc(dealer_cards_r);
                        end else begin
                            player_score_r <= new_score_s;
                            player_soft_r  <= new_soft_s;
                            player_cards_r <= sat_inc(player_cards_r);
                        end
                        if (deal_idx_r < 3'd4) deal_idx_r <= deal_idx_r + 3'd1;
                        if (deal_idx_r == 3'd3) blackjack_r <= (player_score_r == 5'd21);
                    end
                end
                S_PLAYER_TURN: target_r <= 1'b0;
                S_DEALER_TURN: target_r <= 1'b1;
                S_COMPARE:     result_r <= compare_s;
                default: ;
            endcase
        end
    end

    assign get_card     = get_card_r;
    assign player_score = player_score_r;
    assign dealer_score = dealer_score_r;
    assign player_cards = player_cards_r;
    assign dealer_cards = dealer_cards_r;
    assign player_turn  = player_turn_r;
    assign result       = result_r;
    assign blackjack    = blackjack_r;
    assign fault        = fault_r;

endmodule
